conv_mac_seq: RTL and testbench
===============================

CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 SHALL have parameter SIZE, default 3, meaning the window/kernel side length (N = SIZE*SIZE taps).
REQ-002 SHALL have parameter WIDTH_BIT, default 8, meaning the signed width of pixel, kernel and output data.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH_BIT+$clog2(SIZE*SIZE) (20), meaning the signed accumulator width.
REQ-004 SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied to the accumulator before output.
REQ-005 SHALL have port clock  in  1  -- single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  -- synchronous, active-high reset.
REQ-007 SHALL have port k_we  in  1  -- kernel coefficient write strobe.
REQ-008 SHALL have port k_addr  in  $clog2(SIZE*SIZE)  -- row-major coefficient index (row*SIZE+col).
REQ-009 SHALL have port k_data  in  WIDTH_BIT signed  -- coefficient write data.
REQ-010 SHALL have port relu_en  in  1  -- ReLU enable, sampled at window acceptance.
REQ-011 SHALL have port in_valid  in  1  -- input window valid.
REQ-012 SHALL have port in_ready  out  1  -- input window ready.
REQ-013 SHALL have port in_window  in  [SIZE-1:0][SIZE-1:0] x WIDTH_BIT signed  -- input window.
REQ-014 SHALL have port out_valid  out  1  -- result valid.
REQ-015 SHALL have port out_ready  in  1  -- result ready.
REQ-016 SHALL have port out_data  out  WIDTH_BIT signed  -- convolution result.
REQ-017 SHALL have port out_sat  out  1  -- result was clamped.
REQ-018 SHALL have port busy  out  1  -- state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, MAC, NORM and OUT; busy SHALL be 1 in every state except IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE with reset low; a window is accepted on an edge where in_valid && in_ready.
REQ-021 On acceptance, SHALL register in_window, latch relu_en, clear acc, set tap index to 0, and enter MAC.
REQ-022 In MAC, each edge SHALL perform acc += sext(win[idx/SIZE][idx%SIZE] * kernel[idx]) using the full 2*WIDTH_BIT signed product.
REQ-023 In MAC, the tap index SHALL increment each edge; after tap N-1, the state SHALL go to NORM.
REQ-024 In NORM, on one edge SHALL compute r = acc >>> SHIFT (floor), set r = 0 if latched relu_en and r < 0, then clamp to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
REQ-025 The NORM edge SHALL register r into out_data, set out_sat = 1 if clamping changed r (else 0), set out_valid, and enter OUT.
REQ-026 Latency SHALL be exactly N+1 edges from the acceptance edge to out_valid rising (10 for SIZE=3).
REQ-027 In OUT, out_valid, out_data and out_sat SHALL stay stable until out_valid && out_ready.
REQ-028 On that OUT handshake edge, out_valid SHALL go 0 and the state SHALL return to IDLE; out_data and out_sat hold their last value.
REQ-029 There SHALL be no input/output overlap; throughput is one window per N+3 cycles with out_ready held high.
REQ-030 A kernel write SHALL take effect only in IDLE with k_addr < N; writes in other states or with out-of-range addresses SHALL be ignored.
REQ-031 A kernel write in the same IDLE cycle as an acceptance SHALL be used by that computation.
REQ-032 acc SHALL NOT overflow for any inputs when ACC_WIDTH takes its default.

Reset
REQ-033 While reset is high, on the next edge: state = IDLE, out_valid = 0, out_data = 0, out_sat = 0, acc = 0, tap index = 0, all kernel coefficients = 0.
REQ-034 Reset SHALL override any handshake or kernel write in the same cycle.
REQ-035 Reset asserted mid-MAC/NORM/OUT SHALL abort the computation with no result emitted.

Verification
REQ-036 Kernel all 1, window 1..9 row-major, SHIFT=0 -> out_data=45, out_sat=0, out_valid exactly 10 edges after accept.
REQ-037 Kernel all 127, window all 127 -> out_data=127, out_sat=1; kernel all 127, window all -128 -> out_data=-128, out_sat=1.
REQ-038 Kernel center=1 (others 0), window center=-5: relu_en=1 -> out_data=0, out_sat=0; relu_en=0 -> out_data=-5.
REQ-039 Hold out_ready=0 for 5 cycles in OUT while driving in_valid=1 and k_we=1 -> out_data stable, in_ready=0, no acceptance, kernel unchanged; out_ready=1 -> IDLE next edge.
REQ-040 Reset on the 4th MAC cycle -> next edge out_valid=0, busy=0; a following window with no kernel reload gives out_data=0; a write with k_addr=9 is ignored.
REQ-041 SHIFT=2, kernel all 1: window all 3 -> out_data=6; window all -3 -> out_data=-7.

Source files
------------

// File: rtl/conv_mac_seq.sv
// Sequential SIZE x SIZE convolution MAC: one tap per cycle into a wide accumulator,
// then shift / optional ReLU / saturation to a WIDTH_BIT signed result behind a valid/ready handshake.
module conv_mac_seq #(
   parameter int SIZE      = 3,
   parameter int WIDTH_BIT = 8,
   parameter int ACC_WIDTH = 2*WIDTH_BIT + $clog2(SIZE*SIZE),
   parameter int SHIFT     = 0
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        k_we,
   input  logic [$clog2(SIZE*SIZE)-1:0]                k_addr,
   input  logic signed [WIDTH_BIT-1:0]                 k_data,
   input  logic                                        relu_en,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] in_window,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic signed [WIDTH_BIT-1:0]                 out_data,
   output logic                                        out_sat,
   output logic                                        busy
);

   localparam int N     = SIZE*SIZE;
   localparam int IDX_W = $clog2(N);
   localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'(2**(WIDTH_BIT-1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(2**(WIDTH_BIT-1)));

   typedef enum logic [1:0] {IDLE, MAC, NORM, OUT} state_t;

   state_t                        state, state_nxt;
   logic signed [WIDTH_BIT-1:0]   kern   [N];
   logic signed [WIDTH_BIT-1:0]   win_p0 [N];
   logic signed [ACC_WIDTH-1:0]   acc_p1;
   logic [IDX_W-1:0]              idx_p0;
   logic                          relu_p0;
   logic                          accept;
   logic                          k_ok;
   logic                          last_tap;
   logic signed [2*WIDTH_BIT-1:0] prod;
   logic [WIDTH_BIT:0]            norm_res;

   // Floor shift followed by optional ReLU on the full-width accumulator.
   function automatic logic signed [ACC_WIDTH-1:0] shift_relu(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic                        relu
   );
      logic signed [ACC_WIDTH-1:0] r;
      r = a >>> SHIFT;
      if (relu && r[ACC_WIDTH-1]) r = '0;
      return r;
   endfunction

   // Returns {clamped, value} with value limited to the output range.
   function automatic logic [WIDTH_BIT:0] saturate(input logic signed [ACC_WIDTH-1:0] r);
      if (r > OUT_MAX) return {1'b1, OUT_MAX[WIDTH_BIT-1:0]};
      if (r < OUT_MIN) return {1'b1, OUT_MIN[WIDTH_BIT-1:0]};
      return {1'b0, r[WIDTH_BIT-1:0]};
   endfunction

   assign in_ready = (state == IDLE) && !reset;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign k_ok     = k_we && (state == IDLE) && ({1'b0, k_addr} < (IDX_W+1)'(N));
   assign last_tap = (idx_p0 == IDX_W'(N-1));
   assign prod     = win_p0[idx_p0] * kern[idx_p0];
   assign norm_res = saturate(shift_relu(acc_p1, relu_p0));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (last_tap) state_nxt = NORM;
         NORM:    state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Window capture: flattened row-major so the tap index addresses it directly.
   always_ff @(posedge clock) begin
      if (accept) begin
         for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
               win_p0[r*SIZE+c] <= in_window[r][c];
      end
   end

   // Stage p0 -> p1: accumulate one tap per MAC cycle; NORM registers the result.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_p1    <= '0;
         idx_p0    <= '0;
         relu_p0   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         for (int i = 0; i < N; i++) kern[i] <= '0;
      end else begin
         if (k_ok) kern[k_addr] <= k_data;
         case (state)
            IDLE: begin
               if (accept) begin
                  relu_p0 <= relu_en;
                  acc_p1  <= '0;
                  idx_p0  <= '0;
               end
            end
            MAC: begin
               acc_p1 <= acc_p1 + ACC_WIDTH'(prod);
               idx_p0 <= idx_p0 + IDX_W'(1);
            end
            NORM: begin
               out_data  <= norm_res[WIDTH_BIT-1:0];
               out_sat   <= norm_res[WIDTH_BIT];
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomized bench for conv_mac_seq: two instances (SHIFT=0 and SHIFT=2) share stimulus
// and are compared against an arithmetic reference of the convolution.
module tb_conv_mac_seq;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  k_we;
   logic [3:0]            k_addr;
   logic signed [7:0]     k_data;
   logic                  relu_en;
   logic                  in_valid;
   logic                  out_ready;
   logic [2:0][2:0][7:0]  in_window;
   logic                  in_ready, out_valid, out_sat, busy;
   logic signed [7:0]     out_data;
   logic                  in_ready2, out_valid2, out_sat2, busy2;
   logic signed [7:0]     out_data2;

   int mk [9];
   int wm [9];
   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   conv_mac_seq #(.SIZE(3), .WIDTH_BIT(8), .SHIFT(0)) dut (
      .clock(clock), .reset(reset), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
      .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .busy(busy));

   conv_mac_seq #(.SIZE(3), .WIDTH_BIT(8), .SHIFT(2)) dut2 (
      .clock(clock), .reset(reset), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
      .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready2), .in_window(in_window),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2),
      .busy(busy2));

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // Dot product of window and kernel, floor-divided by 2^shift, ReLU, clamp to int8.
   function automatic void model(input int shift, input bit relu, output int d, output bit s);
      int sum;
      sum = 0;
      for (int i = 0; i < 9; i++) sum += wm[i] * mk[i];
      d = sum >>> shift;
      if (relu && d < 0) d = 0;
      s = 1'b0;
      if (d > 127) begin d = 127; s = 1'b1; end
      else if (d < -128) begin d = -128; s = 1'b1; end
   endfunction

   task automatic write_k(input int a, input int d);
      @(negedge clock);
      k_we = 1'b1; k_addr = 4'(a); k_data = 8'(d);
      @(posedge clock); #1;
      k_we = 1'b0;
      if (a < 9) mk[a] = d;
   endtask

   task automatic load_kernel(input int v);
      for (int i = 0; i < 9; i++) write_k(i, v);
   endtask

   task automatic run_window(input string name, input bit relu, input bit kw, input int ka,
                             input int kd, input int hold);
      int d0, d1, lat;
      bit s0, s1;
      @(negedge clock);
      for (int i = 0; i < 9; i++) in_window[i/3][i%3] = 8'(wm[i]);
      relu_en = relu; in_valid = 1'b1; out_ready = (hold == 0);
      k_we = kw; k_addr = 4'(ka); k_data = 8'(kd);
      if (kw && ka < 9) mk[ka] = kd;
      model(0, relu, d0, s0);
      model(2, relu, d1, s1);
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      else n_pass++;
      @(posedge clock); #1;
      in_valid = 1'b0; k_we = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      n_chk++;
      if (lat != 10) $display("FAIL %s latency: got %0d want 10", name, lat);
      else n_pass++;
      n_chk++;
      if ({out_data, out_sat} !== {8'(d0), s0})
         $display("FAIL %s data: got %0d sat %b want %0d sat %b", name, out_data, out_sat, d0, s0);
      else n_pass++;
      n_chk++;
      if ({out_data2, out_sat2} !== {8'(d1), s1})
         $display("FAIL %s data_shift2: got %0d sat %b want %0d sat %b", name, out_data2, out_sat2, d1, s1);
      else n_pass++;
      if (hold > 0) begin
         in_valid = 1'b1; k_we = 1'b1; k_addr = 4'd0; k_data = 8'(mk[0] + 1);
         repeat (hold) begin
            @(posedge clock); #1;
            n_chk++;
            if ({out_valid, in_ready, out_data, out_sat} !== {1'b1, 1'b0, 8'(d0), s0})
               $display("FAIL %s hold: got valid %b ready %b data %0d want 1 0 %0d", name,
                        out_valid, in_ready, out_data, d0);
            else n_pass++;
         end
         out_ready = 1'b1;
      end
      @(posedge clock); #1;
      n_chk++;
      if ({out_valid, busy, out_data} !== {1'b0, 1'b0, 8'(d0)})
         $display("FAIL %s release: got valid %b busy %b data %0d want 0 0 %0d", name,
                  out_valid, busy, out_data, d0);
      else n_pass++;
      in_valid = 1'b0; k_we = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b1; k_we = 1'b1; k_addr = 4'd0; k_data = 8'sd5;
      relu_en = 1'b0; out_ready = 1'b1; in_window = '0;
      repeat (3) @(posedge clock);
      #1;
      n_chk++;
      if ({out_valid, busy, out_data, out_sat, in_ready} !== 12'b0)
         $display("FAIL reset_state: got valid %b busy %b data %0d sat %b ready %b want all 0",
                  out_valid, busy, out_data, out_sat, in_ready);
      else n_pass++;
      reset = 1'b0; in_valid = 1'b0; k_we = 1'b0;
      for (int i = 0; i < 9; i++) mk[i] = 0;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL reset_release in_ready: got %b want 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_basic;
      load_kernel(1);
      for (int i = 0; i < 9; i++) wm[i] = i + 1;
      run_window("basic45", 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_saturation;
      load_kernel(127);
      for (int i = 0; i < 9; i++) wm[i] = 127;
      run_window("sat_pos", 1'b0, 1'b0, 0, 0, 0);
      for (int i = 0; i < 9; i++) wm[i] = -128;
      run_window("sat_neg", 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_relu;
      load_kernel(0);
      write_k(4, 1);
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      wm[4] = -5;
      run_window("relu_on", 1'b1, 1'b0, 0, 0, 0);
      run_window("relu_off", 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_write_on_accept;
      load_kernel(0);
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      wm[4] = 7;
      run_window("write_on_accept", 1'b0, 1'b1, 4, 3, 0);
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 9; i++) write_k(i, rnd8() | 1);
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      run_window("backpressure", 1'b0, 1'b0, 0, 0, 5);
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      run_window("kernel_kept", 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_shift;
      load_kernel(1);
      for (int i = 0; i < 9; i++) wm[i] = 3;
      run_window("shift_pos", 1'b0, 1'b0, 0, 0, 0);
      for (int i = 0; i < 9; i++) wm[i] = -3;
      run_window("shift_neg", 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      int first, second, d0, waited;
      bit s0;
      first = -1; second = -1;
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      @(negedge clock);
      for (int i = 0; i < 9; i++) in_window[i/3][i%3] = 8'(wm[i]);
      relu_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1; k_we = 1'b0;
      for (int i = 0; i < 40 && second < 0; i++) begin
         if (in_ready) begin
            if (first < 0) first = i;
            else second = i;
         end
         @(posedge clock); @(negedge clock);
      end
      in_valid = 1'b0;
      n_chk++;
      if (second - first != 12)
         $display("FAIL back_to_back period: got %0d want 12", second - first);
      else n_pass++;
      waited = 0;
      while (busy !== 1'b0 && waited < 30) begin
         @(posedge clock); #1;
         waited++;
      end
      model(0, 1'b0, d0, s0);
      n_chk++;
      if ({busy, out_data, out_sat} !== {1'b0, 8'(d0), s0})
         $display("FAIL back_to_back drain: got busy %b data %0d want 0 %0d", busy, out_data, d0);
      else n_pass++;
   endtask

   task automatic test_random;
      for (int t = 0; t < 20; t++) begin
         repeat (2) write_k(int'($urandom_range(0, 15)), rnd8());
         for (int i = 0; i < 9; i++) wm[i] = rnd8();
         run_window("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), rnd8(), 0);
      end
   endtask

   task automatic test_abort;
      bit seen;
      for (int i = 0; i < 9; i++) write_k(i, rnd8() | 1);
      for (int i = 0; i < 9; i++) wm[i] = rnd8() | 1;
      @(negedge clock);
      for (int i = 0; i < 9; i++) in_window[i/3][i%3] = 8'(wm[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      n_chk++;
      if ({out_valid, busy, in_ready} !== 3'b000)
         $display("FAIL abort_reset: got valid %b busy %b ready %b want 0 0 0", out_valid, busy, in_ready);
      else n_pass++;
      reset = 1'b0;
      for (int i = 0; i < 9; i++) mk[i] = 0;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clock); #1;
         if (out_valid) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL abort_no_result: got out_valid %b want 0", seen);
      else n_pass++;
      write_k(9, 55);
      for (int i = 0; i < 9; i++) wm[i] = rnd8();
      run_window("abort_zero_kernel", 1'b0, 1'b0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_relu();
      test_write_on_accept();
      test_backpressure();
      test_shift();
      test_back_to_back();
      test_random();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
